// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   RESET_PC_DEFAULT : boot address, must match the PC register reset value
//   PC_INCR          : sequential fetch stride in bytes
//   fetch_state_t    : fetch FSM states
//   fetch_entry_t    : buffered instruction word tagged with its PC
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small instruction buffer between memory responses and decode.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push       write push_data at the tail
//   pop        remove the head (ignored when empty or flushing)
//   flush      discard every entry; wins over push and pop
//   push_data  entry to write
//   head       current head entry (undefined while empty)
//   count      number of valid entries
//   full       count == DEPTH
//   empty      count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_data,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing reads it while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Upstream credit accounting must never let a write hit a full buffer.
  push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: closes the loop around the PC register, fetches
// from instruction memory (one request outstanding at most), buffers words
// with their PC and hands them to decode. Branch/jump/trap redirects flush
// the buffer and squash any stale in-flight response.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   current_PC / next_PC            PC register output / combinational input
//   redirect_valid, redirect_pc     single-cycle redirect and its target
//   imem_req_valid/ready/addr       fetch request (addr = current_PC)
//   imem_rsp_valid/data             in-order read response, one per request
//   inst_valid/ready, inst_data/pc  buffer head presented to decode
//   fetch_fault, fault_pc           only with FETCH_MISALIGN_CHECK_EN: sticky
//                                   misaligned-redirect flag and its target
// Build option: `define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects;
// otherwise redirect targets are silently word-aligned.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] current_PC,
  output logic [31:0] next_PC,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
`endif
);

  fetch_state_t                 state;
  logic [31:0]                  req_pc;
  logic                         fault;
  logic [31:0]                  redirect_target;
  logic                         outstanding;
  logic                         credit;
  logic                         req_hs;
  logic                         push;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         fifo_empty;
  logic                         unused_fifo_full;
  fetch_entry_t                 head;
  fetch_entry_t                 push_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic [31:0] fault_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_pc_q <= '0;
    end else if (redirect_valid) begin
      fault <= |redirect_pc[1:0];
      if (|redirect_pc[1:0]) fault_pc_q <= redirect_pc;
    end
  end

  assign fetch_fault     = fault;
  assign fault_pc        = fault_pc_q;
  assign redirect_target = redirect_pc;
`else
  logic unused_redirect_lsbs;

  assign fault                = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_target      = {redirect_pc[31:2], 2'b00};
`endif

  // A request is only issued if its response is guaranteed a buffer slot.
  assign outstanding = (state != REQ);
  assign credit      = (32'(fifo_count) + 32'(outstanding)) < FIFO_DEPTH;

  assign imem_req_valid = ~rst & (state == REQ) & credit & ~redirect_valid & ~fault;
  assign imem_req_addr  = current_PC;
  assign req_hs         = imem_req_valid & imem_req_ready;

  always_comb begin
    next_PC = current_PC;
    if (rst)                 next_PC = RESET_PC;
    else if (redirect_valid) next_PC = redirect_target;
    else if (req_hs)         next_PC = current_PC + PC_INCR;
  end

  // A response landing in the redirect cycle belongs to the old path.
  assign push       = (state == WAIT) & imem_rsp_valid & ~redirect_valid;
  assign push_entry = '{pc: req_pc, instr: imem_rsp_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= REQ;
      req_pc <= RESET_PC;
    end else begin
      case (state)
        REQ: begin
          if (req_hs) begin
            state  <= WAIT;
            req_pc <= current_PC;
          end
        end
        WAIT: begin
          if (imem_rsp_valid)      state <= REQ;
          else if (redirect_valid) state <= DRAIN;
        end
        DRAIN: begin
          // The owed response is discarded whether or not a redirect arrives.
          if (imem_rsp_valid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (inst_ready),
    .flush     (redirect_valid),
    .push_data (push_entry),
    .head      (head),
    .count     (fifo_count),
    .full      (unused_fifo_full),
    .empty     (fifo_empty)
  );

  assign inst_valid = ~fifo_empty;
  assign inst_data  = head.instr;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: drives the fetch unit with the bench acting as
// PC register, instruction memory and decode, and compares every cycle
// against a queue-level model of fetch order, buffer capacity and redirects.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int unsigned DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] current_PC;
  logic [31:0] next_PC;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
  logic [31:0] fault_pc;
`endif

  instruction_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .current_PC     (current_PC),
    .next_PC        (next_PC),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  mreq_t       mem_q[$];
  ent_t        exp_q[$];
  logic [31:0] req_log[$];
  int unsigned req_cyc[$];
  logic [31:0] pop_log[$];
  int unsigned cyc;
  int unsigned lat_lo, lat_hi, rdy_pct, irdy_pct;
  bit          m_fault;
  logic [31:0] m_fault_pc;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(input bit redir, input logic [31:0] rpc);
    logic [31:0] tgt, nxt, cur;
    bit          exp_rv, hs, rsp;
    cur            = current_PC;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    inst_ready     = ($urandom_range(99) < irdy_pct);
    rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;
    #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    tgt = rpc;
    chk("fetch_fault", fetch_fault, m_fault);
    chk("fault_pc", fault_pc, m_fault_pc);
`else
    tgt = {rpc[31:2], 2'b00};
`endif
    // One outstanding request at most, and only with room for its response.
    exp_rv = !redir && !m_fault && (mem_q.size() == 0) && (exp_q.size() < DEPTH);
    hs     = exp_rv && imem_req_ready;
    nxt    = redir ? tgt : (hs ? cur + 32'd4 : cur);
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, cur);
    chk("next_PC", next_PC, nxt);
    chk("inst_valid", inst_valid, exp_q.size() > 0);
    if (exp_q.size() > 0 && inst_ready && !redir) begin
      chk("inst_pc", inst_pc, exp_q[0].pc);
      chk("inst_data", inst_data, exp_q[0].data);
      pop_log.push_back(exp_q[0].pc);
      void'(exp_q.pop_front());
    end
    if (rsp) begin
      if (!mem_q[0].stale && !redir)
        exp_q.push_back('{pc: mem_q[0].addr, data: mem_word(mem_q[0].addr)});
      void'(mem_q.pop_front());
    end
    if (redir) begin
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      m_fault = (rpc[1:0] != 2'b00);
`ifdef FETCH_MISALIGN_CHECK_EN
      if (m_fault) m_fault_pc = rpc;
`else
      m_fault = 1'b0;
`endif
    end
    if (hs) begin
      mem_q.push_back('{addr: cur, due: cyc + $urandom_range(lat_hi, lat_lo), stale: 1'b0});
      req_log.push_back(cur);
      req_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    current_PC = nxt;
    @(negedge clk);
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick(1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_next_PC", next_PC, RST_PC);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_fetch_fault", fetch_fault, 1'b0);
`endif
    mem_q.delete();
    exp_q.delete();
    req_log.delete();
    req_cyc.delete();
    pop_log.delete();
    m_fault    = 1'b0;
    m_fault_pc = '0;
    current_PC = RST_PC;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    current_PC = RST_PC;

    // Streaming fetch, 1-cycle memory, decode always ready.
    lat_lo = 1; lat_hi = 1; rdy_pct = 100; irdy_pct = 100;
    do_reset();
    run(6);
    chk("stream_req_count", req_log.size(), 3);
    chk("stream_req0", req_log[0], 32'h8000_0000);
    chk("stream_req1", req_log[1], 32'h8000_0004);
    chk("stream_req2", req_log[2], 32'h8000_0008);
    chk("stream_req1_cycle", req_cyc[1], 2);
    chk("stream_req2_cycle", req_cyc[2], 4);
    chk("stream_pop_count", pop_log.size(), 2);
    chk("stream_pop1", pop_log[1], 32'h8000_0004);

    // Decode stalled: buffer fills, fetching stops, PC holds.
    irdy_pct = 0;
    do_reset();
    run(8);
    #1;
    chk("stall_req_count", req_log.size(), 2);
    chk("stall_req_valid", imem_req_valid, 1'b0);
    chk("stall_next_PC", next_PC, 32'h8000_0008);
    irdy_pct = 100;
    run(6);
    chk("resume_req2", req_log[2], 32'h8000_0008);

    // Redirect while waiting on a slow response.
    lat_lo = 3; lat_hi = 3;
    do_reset();
    run(5);
    tick(1'b1, 32'h8000_0100);
    run(4);
    #1;
    chk("drain_req_count", req_log.size(), 3);
    chk("drain_req_target", req_log[2], 32'h8000_0100);
    chk("drain_pop_count", pop_log.size(), 1);
    chk("drain_inst_valid", inst_valid, 1'b0);

    // Redirect in the same cycle as the response.
    lat_lo = 2; lat_hi = 2;
    do_reset();
    run(2);
    tick(1'b1, 32'h8000_0300);
    run(1);
    #1;
    chk("coinc_req_count", req_log.size(), 2);
    chk("coinc_req_target", req_log[1], 32'h8000_0300);
    chk("coinc_pop_count", pop_log.size(), 0);
    chk("coinc_inst_valid", inst_valid, 1'b0);

    // Memory back-pressure: address and PC hold.
    lat_lo = 1; lat_hi = 1; rdy_pct = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 32'h0);
      #1;
      chk("bp_req_addr", imem_req_addr, RST_PC);
      chk("bp_next_PC", next_PC, RST_PC);
    end
    chk("bp_req_count", req_log.size(), 0);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect traps, aligned redirect recovers.
    begin
      int unsigned n_req;
      rdy_pct = 100;
      do_reset();
      run(3);
      tick(1'b1, 32'h8000_0102);
      #1;
      chk("fault_set", fetch_fault, 1'b1);
      chk("fault_pc_val", fault_pc, 32'h8000_0102);
      chk("fault_no_req", imem_req_valid, 1'b0);
      n_req = req_log.size();
      run(4);
      chk("fault_req_frozen", req_log.size(), n_req);
      tick(1'b1, 32'h8000_0200);
      #1;
      chk("fault_cleared", fetch_fault, 1'b0);
      run(3);
      chk("fault_resume_addr", req_log[req_log.size()-1], 32'h8000_0200);
    end
`endif

    // Randomized traffic with occasional redirects and a mid-run reset.
    lat_lo = 1; lat_hi = 3; rdy_pct = 70; irdy_pct = 60;
    do_reset();
    for (int unsigned i = 0; i < 1500; i++) begin
      logic [31:0] rpc;
      if (i == 750) do_reset();
      rpc = $urandom;
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      tick($urandom_range(99) < 4, rpc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
